kernel_seq_mem: RTL and testbench

Parametrised kernel/bias store that feeds the convolution columns, one `GROUP_NB*KER_WIDTH*DEPTH_NB`-bit word per cycle.

- **Write side:** a circular buffer bounded by a software-set end pointer.
- **Read side:** a sequencer loads the first word of a region as bias, then streams the remaining kernel words. The stream repeats a programmable number of passes under valid/ready flow control and signals completion.
- **Position:** sits between the host write path and the convolution column array.

---
 rtl/kernel_seq_mem.sv | 182 ++++++++++++++++++
 tb/tb_kernel_seq_mem.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_seq_mem.sv
// Kernel/bias store for the convolution columns: circular write buffer bounded by
// a software end pointer, and a read sequencer emitting a bias word then N kernel passes.
module kernel_seq_mem #(
  parameter int GROUP_NB   = 4,
  parameter int KER_WIDTH  = 16,
  parameter int DEPTH_NB   = 16,
  parameter int MEM_AWIDTH = 10,
  parameter int MEM_DEPTH  = 1 << MEM_AWIDTH,
  parameter int LOOP_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [MEM_AWIDTH-1:0]                  wr_cfg_end,
  input  logic                                   wr_cfg_set,
  input  logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0] wr_data,
  input  logic                                   wr_data_val,
  output logic                                   wr_data_rdy,
  input  logic [MEM_AWIDTH-1:0]                  rd_cfg_start,
  input  logic [MEM_AWIDTH-1:0]                  rd_cfg_end,
  input  logic [LOOP_WIDTH-1:0]                  rd_cfg_loops,
  input  logic                                   rd_cfg_set,
  output logic                                   rd_cfg_rdy,
  output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0] rd_bias,
  output logic                                   rd_bias_val,
  output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0] rd_data,
  output logic                                   rd_data_val,
  input  logic                                   rd_data_rdy,
  output logic                                   rd_done
);

  localparam int W = GROUP_NB * KER_WIDTH * DEPTH_NB;
  localparam logic [MEM_AWIDTH-1:0] LAST_ADDR = MEM_AWIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIAS,
    S_STREAM
  } state_t;

  function automatic logic [MEM_AWIDTH-1:0] addr_next(input logic [MEM_AWIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  logic [W-1:0] mem [MEM_DEPTH];

  // ---------------- write side ----------------
  logic [MEM_AWIDTH-1:0] wr_ptr;
  logic [MEM_AWIDTH-1:0] wr_end;
  logic                  wr_ptr_wrap;
  logic                  wr_end_wrap;
  logic                  wr_fire;

  assign wr_data_rdy = !((wr_ptr == wr_end) && (wr_ptr_wrap != wr_end_wrap));
  assign wr_fire     = wr_data_val && wr_data_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      wr_ptr_wrap <= 1'b0;
      wr_end      <= '0;
      wr_end_wrap <= 1'b1;
    end else begin
      if (wr_fire) begin
        wr_ptr <= addr_next(wr_ptr);
        if (wr_ptr == LAST_ADDR) begin
          wr_ptr_wrap <= !wr_ptr_wrap;
        end
      end
      if (wr_cfg_set) begin
        wr_end <= wr_cfg_end;
        if (wr_cfg_end <= wr_end) begin
          wr_end_wrap <= !wr_end_wrap;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ---------------- read sequencer ----------------
  state_t                state_q;
  state_t                state_d;
  logic [MEM_AWIDTH-1:0] start_q;
  logic [MEM_AWIDTH-1:0] end_q;
  logic [LOOP_WIDTH-1:0] loops_left;
  logic [MEM_AWIDTH-1:0] rd_ptr;
  logic                  cfg_take;
  logic                  bias_load;
  logic                  issue;
  logic                  done_set;

  assign rd_cfg_rdy = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pass counter reaching zero doubles as the "words remaining" flag.
  always_comb begin
    state_d   = state_q;
    cfg_take  = 1'b0;
    bias_load = 1'b0;
    issue     = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_cfg_set) begin
          cfg_take = 1'b1;
          state_d  = S_BIAS;
        end
      end
      S_BIAS: begin
        bias_load = 1'b1;
        if (start_q == end_q) begin
          done_set = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        issue = (!rd_data_val || rd_data_rdy) && (loops_left != '0);
        if (rd_data_val && rd_data_rdy && (loops_left == '0)) begin
          done_set = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= '0;
      end_q       <= '0;
      loops_left  <= '0;
      rd_ptr      <= '0;
      rd_bias     <= '0;
      rd_bias_val <= 1'b0;
      rd_data     <= '0;
      rd_data_val <= 1'b0;
      rd_done     <= 1'b0;
    end else begin
      rd_done <= done_set;
      if (cfg_take) begin
        start_q     <= rd_cfg_start;
        end_q       <= rd_cfg_end;
        loops_left  <= (rd_cfg_loops == '0) ? LOOP_WIDTH'(1) : rd_cfg_loops;
        rd_ptr      <= rd_cfg_start;
        rd_bias_val <= 1'b0;
      end
      if (bias_load) begin
        rd_bias     <= mem[rd_ptr];
        rd_bias_val <= 1'b1;
        rd_ptr      <= addr_next(start_q);
      end
      if (state_q == S_STREAM) begin
        if (issue) begin
          rd_data     <= mem[rd_ptr];
          rd_data_val <= 1'b1;
          if (rd_ptr == end_q) begin
            rd_ptr     <= addr_next(start_q);
            loops_left <= loops_left - 1'b1;
          end else begin
            rd_ptr <= addr_next(rd_ptr);
          end
        end else if (rd_data_rdy) begin
          rd_data_val <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_seq_mem.sv
// Directed bench for kernel_seq_mem: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_kernel_seq_mem;

  localparam int AW = 4;
  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] wr_cfg_end;
  logic          wr_cfg_set;
  logic [W-1:0]  wr_data;
  logic          wr_data_val;
  logic          wr_data_rdy;
  logic [AW-1:0] rd_cfg_start;
  logic [AW-1:0] rd_cfg_end;
  logic [LW-1:0] rd_cfg_loops;
  logic          rd_cfg_set;
  logic          rd_cfg_rdy;
  logic [W-1:0]  rd_bias;
  logic          rd_bias_val;
  logic [W-1:0]  rd_data;
  logic          rd_data_val;
  logic          rd_data_rdy;
  logic          rd_done;

  kernel_seq_mem #(
    .GROUP_NB  (2),
    .KER_WIDTH (4),
    .DEPTH_NB  (2),
    .MEM_AWIDTH(AW),
    .MEM_DEPTH (16),
    .LOOP_WIDTH(LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_cfg_end  (wr_cfg_end),
    .wr_cfg_set  (wr_cfg_set),
    .wr_data     (wr_data),
    .wr_data_val (wr_data_val),
    .wr_data_rdy (wr_data_rdy),
    .rd_cfg_start(rd_cfg_start),
    .rd_cfg_end  (rd_cfg_end),
    .rd_cfg_loops(rd_cfg_loops),
    .rd_cfg_set  (rd_cfg_set),
    .rd_cfg_rdy  (rd_cfg_rdy),
    .rd_bias     (rd_bias),
    .rd_bias_val (rd_bias_val),
    .rd_data     (rd_data),
    .rd_data_val (rd_data_val),
    .rd_data_rdy (rd_data_rdy),
    .rd_done     (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  bit         model_ok = 0;
  logic [W-1:0] m_mem [16];
  logic [4:0] m_ptr5;      // write pointer with wrap as 5th bit
  logic [4:0] m_end5;      // end pointer with wrap as 5th bit
  bit         m_busy;
  int         m_age;
  int         m_start;
  int         addr_q[$];
  logic [W-1:0] m_bias;
  bit         m_bias_val;
  logic [W-1:0] m_out;
  bit         m_out_val;
  bit         m_done;
  int         n_words;
  int         n_loops;
  bit         ewrap;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ptr5     = '0;
      m_end5     = 5'd16;
      m_busy     = 0;
      m_age      = 0;
      addr_q.delete();
      m_bias     = '0;
      m_bias_val = 0;
      m_out      = '0;
      m_out_val  = 0;
      m_done     = 0;
      model_ok   = 1;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (rd_cfg_set) begin
          m_busy     = 1;
          m_age      = 0;
          m_start    = int'(rd_cfg_start);
          m_bias_val = 0;
          n_words    = (int'(rd_cfg_end) - int'(rd_cfg_start)) & 15;
          n_loops    = (rd_cfg_loops == '0) ? 1 : int'(rd_cfg_loops);
          for (int p = 0; p < n_loops; p++)
            for (int k = 1; k <= n_words; k++)
              addr_q.push_back((m_start + k) & 15);
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          m_bias     = m_mem[m_start];
          m_bias_val = 1;
          if (addr_q.size() == 0) begin
            m_done = 1;
            m_busy = 0;
          end
        end else if (!m_out_val || rd_data_rdy) begin
          if (addr_q.size() != 0) begin
            m_out     = m_mem[addr_q.pop_front()];
            m_out_val = 1;
          end else begin
            m_out_val = 0;
            m_done    = 1;
            m_busy    = 0;
          end
        end
      end
      // write side after reads: same-edge writes are not visible to this edge's reads
      if (wr_data_val && ((m_end5 - m_ptr5) != 5'd16)) begin
        m_mem[m_ptr5[3:0]] = wr_data;
        m_ptr5 = m_ptr5 + 5'd1;
      end
      if (wr_cfg_set) begin
        ewrap = m_end5[4];
        if (wr_cfg_end <= m_end5[3:0]) ewrap = !ewrap;
        m_end5 = {ewrap, wr_cfg_end};
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("wr_data_rdy", 32'(wr_data_rdy), 32'((m_end5 - m_ptr5) != 5'd16));
      chk("rd_cfg_rdy",  32'(rd_cfg_rdy),  32'(!m_busy));
      chk("rd_bias_val", 32'(rd_bias_val), 32'(m_bias_val));
      chk("rd_bias",     32'(rd_bias),     32'(m_bias));
      chk("rd_data_val", 32'(rd_data_val), 32'(m_out_val));
      chk("rd_data",     32'(rd_data),     32'(m_out));
      chk("rd_done",     32'(rd_done),     32'(m_done));
    end
  end

  // ---------------- scenario observation ----------------
  int got[$];
  int exp_seq[$];
  int val_cnt  = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int t_set    = 0;
  int acc;

  always @(negedge clk) begin
    if (rd_data_val && rd_data_rdy) got.push_back(int'(rd_data));
    if (rd_data_val) val_cnt++;
    if (rd_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int s, input int e, input int l, input bit tog,
                         input int exp_bias, input int exp_lat);
    int k;
    got.delete();
    val_cnt  = 0;
    done_cnt = 0;
    rd_cfg_start = AW'(s);
    rd_cfg_end   = AW'(e);
    rd_cfg_loops = LW'(l);
    rd_cfg_set   = 1'b1;
    rd_data_rdy  = !tog;
    t_set = cyc;
    tick();
    rd_cfg_set = 1'b0;
    if (tog) rd_data_rdy = !rd_data_rdy;
    @(negedge clk);
    chk("bias_val_t1", 32'(rd_bias_val), 32'd0);
    tick();
    if (tog) rd_data_rdy = !rd_data_rdy;
    @(negedge clk);
    chk("bias_val_t2", 32'(rd_bias_val), 32'd1);
    chk("bias_t2", 32'(rd_bias), 32'(exp_bias));
    k = 0;
    while (done_cnt == 0 && k < 80) begin
      tick();
      if (tog) rd_data_rdy = !rd_data_rdy;
      k++;
    end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    rd_data_rdy = 1'b1;
    repeat (3) tick();
    chk("done_count", 32'(done_cnt), 32'd1);
    if (exp_lat >= 0) chk("done_latency", 32'(done_cyc - t_set), 32'(exp_lat));
    chk("xfer_count", 32'(got.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (i < got.size()) chk("xfer_data", 32'(got[i]), 32'(exp_seq[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_cfg_end = '0; wr_cfg_set = 1'b0; wr_data = '0; wr_data_val = 1'b0;
    rd_cfg_start = '0; rd_cfg_end = '0; rd_cfg_loops = '0; rd_cfg_set = 1'b0;
    rd_data_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_before_cfg", 32'(wr_data_rdy), 32'd0);
    chk("reset_cfg_rdy", 32'(rd_cfg_rdy), 32'd1);

    // fill: end=8, ten offered words, only addresses 0..7 accepted
    wr_cfg_end = 4'd8; wr_cfg_set = 1'b1;
    tick();
    wr_cfg_set = 1'b0;
    acc = 0;
    wr_data_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = W'(i);
      if (wr_data_rdy) acc++;
      tick();
    end
    wr_data_val = 1'b0;
    chk("fill_accepted", 32'(acc), 32'd8);
    @(negedge clk);
    chk("rdy_after_fill", 32'(wr_data_rdy), 32'd0);

    exp_seq = '{1, 2, 3, 4};
    run_seq(0, 4, 1, 1'b0, 0, 7);

    exp_seq = '{3, 4, 3, 4, 3, 4};
    run_seq(2, 4, 3, 1'b1, 2, -1);

    exp_seq.delete();
    run_seq(5, 5, 1, 1'b0, 5, 2);
    chk("zero_no_val", 32'(val_cnt), 32'd0);

    // end pointer moved below the old end: wrap toggles, writes cross address 0
    wr_cfg_end = 4'd2; wr_cfg_set = 1'b1;
    tick();
    wr_cfg_set = 1'b0;
    acc = 0;
    wr_data_val = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_data = 16'h0100 + W'((8 + acc) & 15);
      if (wr_data_rdy) acc++;
      tick();
    end
    wr_data_val = 1'b0;
    chk("wrap_accepted", 32'(acc), 32'd10);
    @(negedge clk);
    chk("rdy_after_wrap", 32'(wr_data_rdy), 32'd0);

    exp_seq = '{16'h010F, 16'h0100, 16'h0101};
    run_seq(14, 1, 1, 1'b0, 16'h010E, 6);

    // abort: ignored mid-stream cfg, then reset mid-stream
    rd_cfg_start = 4'd2; rd_cfg_end = 4'd7; rd_cfg_loops = 8'd2; rd_cfg_set = 1'b1;
    rd_data_rdy = 1'b1;
    tick();
    rd_cfg_set = 1'b0;
    repeat (3) tick();
    rd_cfg_start = 4'd9; rd_cfg_end = 4'd9; rd_cfg_loops = 8'd1; rd_cfg_set = 1'b1;
    tick();
    rd_cfg_set = 1'b0;
    @(negedge clk);
    chk("ignored_cfg_busy", 32'(rd_cfg_rdy), 32'd0);
    chk("stream_mid_val", 32'(rd_data_val), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_wr_rdy",    32'(wr_data_rdy), 32'd0);
    chk("abort_cfg_rdy",   32'(rd_cfg_rdy),  32'd1);
    chk("abort_bias",      32'(rd_bias),     32'd0);
    chk("abort_bias_val",  32'(rd_bias_val), 32'd0);
    chk("abort_data",      32'(rd_data),     32'd0);
    chk("abort_data_val",  32'(rd_data_val), 32'd0);
    chk("abort_done",      32'(rd_done),     32'd0);

    exp_seq = '{2, 3};
    run_seq(1, 3, 0, 1'b0, 16'h0101, 5);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
